seq_mult_ctrl: RTL and testbench

SEQ_MULT_CTRL -- requirements
Module: seq_mult_ctrl

---
 rtl/seq_mult_ctrl.sv | 86 ++++++++
 tb/tb_seq_mult_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_mult_ctrl.sv
// Sequential shift-add multiplier: one multiplier row per RUN cycle, using a
// single 2*WIDTH accumulator whose low half initially holds the multiplier.
module seq_mult_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rstN,
  input  logic               start,
  input  logic [WIDTH-1:0]   mIn,
  input  logic [WIDTH-1:0]   qIn,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, stateNext;
  logic [WIDTH-1:0]   m;
  logic [2*WIDTH-1:0] acc, accNext;
  logic [CW-1:0]      rowCnt;
  logic [WIDTH:0]     sum;
  logic               lastRow, load, step;

  // The extra sum bit keeps the carry, which becomes the new accumulator MSB
  assign sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, m} : '0);
  assign accNext = {sum, acc[WIDTH-1:1]};
  assign lastRow = (rowCnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    busy      = 1'b0;
    done      = 1'b0;
    load      = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          stateNext = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        step = 1'b1;
        if (lastRow) stateNext = DONE;
      end
      DONE: begin
        done = 1'b1;
        // A start here chains straight into the next operation
        if (start) begin
          load      = 1'b1;
          stateNext = RUN;
        end else begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      m       <= '0;
      acc     <= '0;
      rowCnt  <= '0;
      product <= '0;
    end else if (load) begin
      m       <= mIn;
      acc     <= {{WIDTH{1'b0}}, qIn};
      rowCnt  <= '0;
    end else if (step) begin
      acc    <= accNext;
      rowCnt <= rowCnt + CW'(1);
      if (lastRow) product <= accNext;
    end
  end

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Self-checking bench for seq_mult_ctrl at WIDTH=4 and WIDTH=16, compared
// against plain multiplication and the expected WIDTH-edge latency.
module tb_seq_mult_ctrl;

  logic        clk;
  logic        rstN;
  logic        start4, busy4, done4;
  logic [3:0]  mIn4, qIn4;
  logic [7:0]  product4;
  logic        start16, busy16, done16;
  logic [15:0] mIn16, qIn16;
  logic [31:0] product16;

  int compared   = 0;
  int mismatched = 0;

  seq_mult_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rstN(rstN), .start(start4), .mIn(mIn4), .qIn(qIn4),
    .busy(busy4), .done(done4), .product(product4)
  );

  seq_mult_ctrl #(.WIDTH(16)) dut16 (
    .clk(clk), .rstN(rstN), .start(start16), .mIn(mIn16), .qIn(qIn16),
    .busy(busy16), .done(done16), .product(product16)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Starts one operation, scrambles the operand inputs after the accepting
  // edge, and reports result, edges-to-done and cycles seen busy.
  task automatic do_op(input bit wide, input logic [15:0] a, input logic [15:0] b,
                       output logic [31:0] p, output int lat, output int busyCnt);
    int limit;
    limit = wide ? 40 : 20;
    @(negedge clk);
    if (wide) begin start16 = 1'b1; mIn16 = a; qIn16 = b; end
    else begin start4 = 1'b1; mIn4 = a[3:0]; qIn4 = b[3:0]; end
    @(negedge clk);
    start4 = 1'b0; start16 = 1'b0;
    mIn4 = 4'($urandom); qIn4 = 4'($urandom);
    mIn16 = 16'($urandom); qIn16 = 16'($urandom);
    lat = 0; busyCnt = 0;
    while (!(wide ? done16 : done4) && lat < limit) begin
      if (wide ? busy16 : busy4) busyCnt++;
      @(negedge clk);
      lat++;
    end
    p = wide ? product16 : {24'b0, product4};
  endtask

  task automatic test_reset();
    rstN = 1'b0; start4 = 1'b0; start16 = 1'b0;
    mIn4 = '0; qIn4 = '0; mIn16 = '0; qIn16 = '0;
    repeat (2) @(negedge clk);
    compared++;
    if ({busy4, done4, product4} !== 10'b0) begin
      mismatched++;
      $display("[TB] FAIL reset4: got busy=%b done=%b product=%0d, want 0/0/0", busy4, done4, product4);
    end
    compared++;
    if ({busy16, done16, product16} !== 34'b0) begin
      mismatched++;
      $display("[TB] FAIL reset16: got busy=%b done=%b product=%0d, want 0/0/0", busy16, done16, product16);
    end
    rstN = 1'b1;
  endtask

  task automatic test_basic();
    logic [31:0] p; int lat, bc;
    do_op(1'b0, 16'd13, 16'd11, p, lat, bc);
    compared++;
    if (p !== 32'd143) begin mismatched++; $display("[TB] FAIL basic_product: got %0d, want 143", p); end
    compared++;
    if (lat !== 4) begin mismatched++; $display("[TB] FAIL basic_latency: got %0d, want 4", lat); end
    compared++;
    if (bc !== 4) begin mismatched++; $display("[TB] FAIL basic_busy: got %0d cycles, want 4", bc); end
    @(negedge clk);
    compared++;
    if ({done4, busy4} !== 2'b00) begin
      mismatched++;
      $display("[TB] FAIL basic_after: got done=%b busy=%b, want 0/0", done4, busy4);
    end
  endtask

  task automatic test_corners();
    logic [31:0] p; int lat, bc;
    logic [3:0] ma [3] = '{4'd15, 4'd0, 4'd9};
    logic [3:0] qa [3] = '{4'd15, 4'd15, 4'd0};
    for (int i = 0; i < 3; i++) begin
      do_op(1'b0, {12'b0, ma[i]}, {12'b0, qa[i]}, p, lat, bc);
      compared++;
      if (p !== 32'(ma[i]) * 32'(qa[i]) || lat !== 4) begin
        mismatched++;
        $display("[TB] FAIL corner %0d*%0d: got product=%0d lat=%0d, want %0d lat=4",
                 ma[i], qa[i], p, lat, 32'(ma[i]) * 32'(qa[i]));
      end
    end
  endtask

  task automatic test_ignore_start();
    int lat;
    @(negedge clk);
    start4 = 1'b1; mIn4 = 4'd13; qIn4 = 4'd11;
    @(negedge clk);
    start4 = 1'b0;
    lat = 0;
    while (!done4 && lat < 20) begin
      @(negedge clk);
      lat++;
      if (lat == 2) begin start4 = 1'b1; mIn4 = 4'd2; qIn4 = 4'd3; end
      else if (lat == 3) start4 = 1'b0;
    end
    compared++;
    if (product4 !== 8'd143 || lat !== 4) begin
      mismatched++;
      $display("[TB] FAIL ignore_start: got product=%0d lat=%0d, want 143 lat=4", product4, lat);
    end
    @(negedge clk);
    compared++;
    if ({done4, busy4} !== 2'b00) begin
      mismatched++;
      $display("[TB] FAIL ignore_done_pulse: got done=%b busy=%b, want 0/0", done4, busy4);
    end
  endtask

  task automatic test_back_to_back();
    int lat; bit held;
    @(negedge clk);
    start4 = 1'b1; mIn4 = 4'd13; qIn4 = 4'd11;
    @(negedge clk);
    start4 = 1'b0;
    lat = 0;
    while (!done4 && lat < 20) begin @(negedge clk); lat++; end
    compared++;
    if (product4 !== 8'd143) begin mismatched++; $display("[TB] FAIL b2b_first: got %0d, want 143", product4); end
    start4 = 1'b1; mIn4 = 4'd3; qIn4 = 4'd5;
    @(negedge clk);
    start4 = 1'b0;
    compared++;
    if (busy4 !== 1'b1 || done4 !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL b2b_no_gap: got busy=%b done=%b, want 1/0", busy4, done4);
    end
    lat = 0; held = 1'b1;
    while (!done4 && lat < 20) begin
      if (product4 !== 8'd143) held = 1'b0;
      @(negedge clk);
      lat++;
    end
    compared++;
    if (!held) begin mismatched++; $display("[TB] FAIL b2b_hold: got held=%b, want 1", held); end
    compared++;
    if (product4 !== 8'd15 || lat !== 4) begin
      mismatched++;
      $display("[TB] FAIL b2b_second: got product=%0d lat=%0d, want 15 lat=4", product4, lat);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] p; int lat, bc; bit sawDone;
    @(negedge clk);
    start4 = 1'b1; mIn4 = 4'd13; qIn4 = 4'd11;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    #2 rstN = 1'b0;
    #1;
    compared++;
    if ({busy4, done4, product4} !== 10'b0) begin
      mismatched++;
      $display("[TB] FAIL async_reset: got busy=%b done=%b product=%0d, want 0/0/0", busy4, done4, product4);
    end
    sawDone = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done4 || busy4) sawDone = 1'b1;
    end
    rstN = 1'b1;
    compared++;
    if (sawDone) begin mismatched++; $display("[TB] FAIL async_abort: got activity=%b, want 0", sawDone); end
    do_op(1'b0, 16'd7, 16'd6, p, lat, bc);
    compared++;
    if (p !== 32'd42 || lat !== 4) begin
      mismatched++;
      $display("[TB] FAIL async_recover: got product=%0d lat=%0d, want 42 lat=4", p, lat);
    end
  endtask

  task automatic test_sweep4();
    int order [256];
    logic [31:0] p, exp; int lat, bc, j, tmp;
    for (int i = 0; i < 256; i++) order[i] = i;
    for (int i = 255; i > 0; i--) begin
      j = int'($urandom_range(i, 0));
      tmp = order[i]; order[i] = order[j]; order[j] = tmp;
    end
    for (int i = 0; i < 256; i++) begin
      exp = 32'(order[i] / 16) * 32'(order[i] % 16);
      do_op(1'b0, 16'(order[i] / 16), 16'(order[i] % 16), p, lat, bc);
      compared++;
      if (p !== exp || lat !== 4) begin
        mismatched++;
        $display("[TB] FAIL sweep4 %0d*%0d: got product=%0d lat=%0d, want %0d lat=4",
                 order[i] / 16, order[i] % 16, p, lat, exp);
      end
    end
  endtask

  task automatic test_random16();
    logic [15:0] a, b;
    logic [31:0] p, exp; int lat, bc;
    for (int i = 0; i < 1000; i++) begin
      a = 16'($urandom); b = 16'($urandom);
      if (i == 0) begin a = 16'hFFFF; b = 16'hFFFF; end
      if (i == 1) begin a = 16'h0000; b = 16'hFFFF; end
      exp = 32'(a) * 32'(b);
      do_op(1'b1, a, b, p, lat, bc);
      compared++;
      if (p !== exp || lat !== 16) begin
        mismatched++;
        $display("[TB] FAIL random16 %0d*%0d: got product=%0d lat=%0d, want %0d lat=16", a, b, p, lat, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_ignore_start();
    test_back_to_back();
    test_async_reset();
    test_sweep4();
    test_random16();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
